// File: rtl/ama_riscv_fetch.sv
// Instruction fetch stage: PC register, synchronous-IMEM interface and the IF/ID
// boundary (stall hold buffer, squash flag, reset bubble).
module ama_riscv_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          IMEM_AW   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic               pc_we,
  input  logic [31:0]        alu_out,
  input  logic               stall_if,
  input  logic               clear_if,
  input  logic [31:0]        imem_rdata,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  output logic [31:0]        pc_if,
  output logic [31:0]        pc_id,
  output logic [31:0]        inst_id,
  output logic               inst_valid_id
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SEL_INC4  = 2'd0,
    PC_SEL_ALU   = 2'd1,
    PC_SEL_RSVD  = 2'd2,
    PC_SEL_START = 2'd3
  } pc_sel_e;

  pc_sel_e     sel;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        clr_q, clr_d;
  logic        rst_seq_q;
  logic        unused_alu_lsbs;

  assign sel             = pc_sel_e'(pc_sel);
  assign unused_alu_lsbs = ^alu_out[1:0];

  // Next PC: the PC only moves when the decoder asks and the stage is not frozen.
  // A squash does not gate this, so a redirect lands together with its bubble.
  always_comb begin
    pc_if_d = pc_if_q;
    if (pc_we && !stall_if) begin
      case (sel)
        PC_SEL_INC4:  pc_if_d = pc_if_q + 32'd4;
        PC_SEL_ALU:   pc_if_d = {alu_out[31:2], 2'b00};
        PC_SEL_START: pc_if_d = RESET_VEC;
        PC_SEL_RSVD:  pc_if_d = pc_if_q;
        default:      pc_if_d = pc_if_q;
      endcase
    end
  end

  assign pc_id_d = stall_if ? pc_id_q : pc_if_q;

  // IMEM output is only trustworthy on the first stalled cycle (no read is issued
  // afterwards), so capture it once and replay it until the stall lifts.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (clear_if || !stall_if) begin
      hold_vld_d = 1'b0;
    end else if (!hold_vld_q) begin
      hold_d     = imem_rdata;
      hold_vld_d = 1'b1;
    end
  end

  // The squash sticks through a stall so the bubble is not lost while frozen.
  always_comb begin
    clr_d = clr_q;
    if (clear_if)
      clr_d = 1'b1;
    else if (!stall_if)
      clr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_if_q    <= RESET_VEC;
      pc_id_q    <= RESET_VEC;
      hold_q     <= NOP;
      hold_vld_q <= 1'b0;
      clr_q      <= 1'b0;
      rst_seq_q  <= 1'b1;
    end else begin
      pc_if_q    <= pc_if_d;
      pc_id_q    <= pc_id_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      clr_q      <= clr_d;
      rst_seq_q  <= 1'b0;
    end
  end

  assign imem_addr     = pc_if_q[IMEM_AW+1:2];
  assign imem_en       = !stall_if;
  assign pc_if         = pc_if_q;
  assign pc_id         = pc_id_q;
  assign inst_valid_id = !rst_seq_q && !clr_q;

  always_comb begin
    inst_id = imem_rdata;
    if (!inst_valid_id)
      inst_id = NOP;
    else if (hold_vld_q)
      inst_id = hold_q;
  end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for ama_riscv_fetch: cycle table from reset plus async-reset sequences.
module tb_ama_riscv_fetch;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    pc_sel;
  logic          pc_we;
  logic [31:0]   alu_out;
  logic          stall_if;
  logic          clear_if;
  logic [31:0]   imem_rdata;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [31:0]   pc_if;
  logic [31:0]   pc_id;
  logic [31:0]   inst_id;
  logic          inst_valid_id;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  ama_riscv_fetch #(.RESET_VEC(32'h0000_0000), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_we(pc_we), .alu_out(alu_out),
    .stall_if(stall_if), .clear_if(clear_if), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .imem_en(imem_en), .pc_if(pc_if), .pc_id(pc_id),
    .inst_id(inst_id), .inst_valid_id(inst_valid_id)
  );

  // clock / memory model
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = i + 1;
  end

  // Synchronous IMEM: data is garbage unless a read was issued on the last edge.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    else         imem_rdata <= 'x;
  end

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [31:0] alu;
    logic        stall;
    logic        clear;
    logic [31:0] e_pc_if;
    logic [31:0] e_pc_id;
    logic [31:0] e_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic [1:0] sel, logic we, logic [31:0] alu, logic stall,
                              logic clear, logic [31:0] epc, logic [31:0] epid,
                              logic [31:0] einst, logic ev);
    vec_t v;
    v.sel = sel; v.we = we; v.alu = alu; v.stall = stall; v.clear = clear;
    v.e_pc_if = epc; v.e_pc_id = epid; v.e_inst = einst; v.e_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic we, input logic [31:0] alu,
                       input logic stall, input logic clear);
    pc_sel = sel; pc_we = we; alu_out = alu; stall_if = stall; clear_if = clear;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(2'd0, 1, 32'h0,   0, 0, 32'h0,   32'h0,   32'h13, 0);
    vecs[1]  = mk(2'd0, 1, 32'h0,   0, 0, 32'h4,   32'h0,   32'h1,  1);
    vecs[2]  = mk(2'd0, 1, 32'h0,   0, 0, 32'h8,   32'h4,   32'h2,  1);
    vecs[3]  = mk(2'd0, 1, 32'h0,   0, 0, 32'hC,   32'h8,   32'h3,  1);
    vecs[4]  = mk(2'd0, 1, 32'h0,   0, 0, 32'h10,  32'hC,   32'h4,  1);
    vecs[5]  = mk(2'd0, 1, 32'h0,   1, 0, 32'h14,  32'h10,  32'h5,  1);
    vecs[6]  = mk(2'd0, 1, 32'h0,   1, 0, 32'h14,  32'h10,  32'h5,  1);
    vecs[7]  = mk(2'd0, 1, 32'h0,   1, 0, 32'h14,  32'h10,  32'h5,  1);
    vecs[8]  = mk(2'd0, 1, 32'h0,   0, 0, 32'h14,  32'h10,  32'h5,  1);
    vecs[9]  = mk(2'd0, 1, 32'h0,   0, 0, 32'h18,  32'h14,  32'h6,  1);
    vecs[10] = mk(2'd1, 1, 32'h102, 0, 1, 32'h1C,  32'h18,  32'h7,  1);
    vecs[11] = mk(2'd0, 1, 32'h0,   0, 0, 32'h100, 32'h1C,  32'h13, 0);
    vecs[12] = mk(2'd0, 1, 32'h0,   0, 0, 32'h104, 32'h100, 32'h41, 1);
    vecs[13] = mk(2'd0, 1, 32'h0,   1, 1, 32'h108, 32'h104, 32'h42, 1);
    vecs[14] = mk(2'd0, 1, 32'h0,   1, 1, 32'h108, 32'h104, 32'h13, 0);
    vecs[15] = mk(2'd0, 1, 32'h0,   0, 0, 32'h108, 32'h104, 32'h13, 0);
    vecs[16] = mk(2'd0, 1, 32'h0,   0, 0, 32'h10C, 32'h108, 32'h43, 1);
    vecs[17] = mk(2'd3, 1, 32'h0,   0, 0, 32'h110, 32'h10C, 32'h44, 1);
    vecs[18] = mk(2'd2, 1, 32'h0,   0, 0, 32'h0,   32'h110, 32'h45, 1);
    vecs[19] = mk(2'd0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   32'h1,  1);
    vecs[20] = mk(2'd1, 1, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h0, 32'h1, 1);
    vecs[21] = mk(2'd0, 1, 32'h0,   0, 0, 32'hFFFF_FFFC, 32'h0, 32'h1, 1);
    vecs[22] = mk(2'd0, 1, 32'h0,   0, 0, 32'h0,   32'hFFFF_FFFC, 32'h4000, 1);
    vecs[23] = mk(2'd0, 1, 32'h0,   0, 0, 32'h4,   32'h0,   32'h1,  1);

    // reset
    rst = 1'b1;
    drive(2'd0, 1, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_inst", inst_id, 32'h13);
    chk("rst_valid", {31'b0, inst_valid_id}, 32'h0);

    // cycle table
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      drive(vecs[i].sel, vecs[i].we, vecs[i].alu, vecs[i].stall, vecs[i].clear);
      #1;
      chk($sformatf("v%0d_pc_if", i), pc_if, vecs[i].e_pc_if);
      chk($sformatf("v%0d_pc_id", i), pc_id, vecs[i].e_pc_id);
      chk($sformatf("v%0d_inst", i), inst_id, vecs[i].e_inst);
      chk($sformatf("v%0d_valid", i), {31'b0, inst_valid_id}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_en", i), {31'b0, imem_en}, {31'b0, !vecs[i].stall});
      chk($sformatf("v%0d_addr", i), {18'b0, imem_addr}, {18'b0, vecs[i].e_pc_if[AW+1:2]});
    end

    // async reset in the middle of a stall: held instruction must be discarded
    @(negedge clk);
    drive(2'd0, 1, 32'h0, 1, 0);
    #1;
    chk("st_inst", inst_id, 32'h2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc_if", pc_if, 32'h0);
    chk("arst_pc_id", pc_id, 32'h0);
    chk("arst_inst", inst_id, 32'h13);
    chk("arst_valid", {31'b0, inst_valid_id}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'd0, 1, 32'h0, 0, 0);
    #1;
    chk("arel_inst", inst_id, 32'h13);
    chk("arel_valid", {31'b0, inst_valid_id}, 32'h0);
    @(negedge clk);
    #1;
    chk("arel1_inst", inst_id, 32'h1);
    chk("arel1_pc_id", pc_id, 32'h0);
    chk("arel1_valid", {31'b0, inst_valid_id}, 32'h1);
    chk("arel1_pc_if", pc_if, 32'h4);

    // async reset while a squash is pending: it must not survive the reset
    @(negedge clk);
    drive(2'd0, 1, 32'h0, 0, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive(2'd0, 1, 32'h0, 1, 0);
    #1;
    chk("crst_pc_if", pc_if, 32'h0);
    chk("crst_valid", {31'b0, inst_valid_id}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("crel_valid", {31'b0, inst_valid_id}, 32'h0);
    chk("crel_en", {31'b0, imem_en}, 32'h0);
    @(negedge clk);
    #1;
    chk("crel1_valid", {31'b0, inst_valid_id}, 32'h1);
    chk("crel1_pc_if", pc_if, 32'h0);
    chk("crel1_pc_id", pc_id, 32'h0);

    drive(2'd0, 1, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
